display_digit_driver: RTL and testbench

Digit-data stage for the 4-digit seven-segment scan path. It accepts a 14-bit binary value over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine. It commits the new digits only at a scan-frame boundary, so the display never tears. For the digit currently selected by the upstream 2-bit scan counter (i_Sel / i_Anodos), it outputs the registered segment pattern aligned with a registered copy of the anodes.

---
 rtl/display_digit_driver.sv | 150 +++++++++++++++
 tb/tb_display_digit_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_digit_driver.sv
// display_digit_driver: 14-bit binary to 4-digit BCD via double-dabble,
// committed at scan-frame boundary, driving one registered digit per cycle.
module display_digit_driver #(
  parameter bit P_BLANK_LZ       = 1'b1,
  parameter bit P_SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [13:0] i_Data,
  input  logic [1:0]  i_Sel,
  input  logic [3:0]  i_Anodos,
  output logic [3:0]  o_Anodos,
  output logic [6:0]  o_Segmentos,
  output logic        o_Ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    WAIT
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_OFF   =
    P_SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t      state;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [3:0]  cnt;
  logic        pend_ovf;
  logic [15:0] disp;
  logic        disp_ovf;

  logic [15:0] bcd_adj;
  logic [3:0]  blank;
  logic [3:0]  nib;
  logic [6:0]  code;

  function automatic logic [6:0] seg_enc(
    input logic [3:0] n
  );
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction of every BCD nibble ahead of the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking flags; units digit is never blanked
  always_comb begin
    blank    = 4'b0000;
    blank[3] = P_BLANK_LZ && (disp[15:12] == 4'd0);
    blank[2] = blank[3] && (disp[11:8] == 4'd0);
    blank[1] = blank[2] && (disp[7:4] == 4'd0);
  end

  // Segment pattern for the digit picked by the scan index
  always_comb begin
    nib = disp[{i_Sel, 2'b00} +: 4];
    if (disp_ovf)
      code = SEG_DASH;
    else if (blank[i_Sel])
      code = SEG_BLANK;
    else
      code = seg_enc(nib);
  end

  // Handshake, conversion and frame-aligned commit
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= IDLE;
      o_Ready  <= 1'b1;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      pend_ovf <= 1'b0;
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_Valid) begin
            bin      <= i_Data;
            pend_ovf <= (i_Data > 14'd9999);
            bcd      <= '0;
            cnt      <= 4'd14;
            o_Ready  <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
          cnt        <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= WAIT;
        end
        WAIT: begin
          if (i_Sel == 2'd3) begin
            disp     <= bcd;
            disp_ovf <= pend_ovf;
            o_Ready  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          o_Ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Output register keeps segments aligned with the delayed anodes
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Segmentos <= SEG_OFF;
      o_Anodos    <= 4'b0000;
    end else begin
      o_Segmentos <= P_SEG_ACTIVE_LOW ? ~code : code;
      o_Anodos    <= i_Anodos;
    end
  end

  assign o_Ovf = disp_ovf;

endmodule

// File: tb/tb_display_digit_driver.sv
// tb_display_digit_driver: directed vectors for the BCD display stage,
// three parameter variants sharing one stimulus stream.
module tb_display_digit_driver;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Valid;
  logic [13:0] i_Data;
  logic [1:0]  i_Sel;
  logic [3:0]  i_Anodos;

  logic        m_rdy, n_rdy, a_rdy;
  logic [3:0]  m_an, n_an, a_an;
  logic [6:0]  m_seg, n_seg, a_seg;
  logic        m_ovf, n_ovf, a_ovf;

  int checks = 0;
  int errors = 0;
  logic       scan_en;
  logic [1:0] prev_sel;

  typedef logic [6:0] seg4_t [4];

  always #5 i_Clk = ~i_Clk;

  display_digit_driver u_dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Valid(i_Valid), .o_Ready(m_rdy),
    .i_Data(i_Data), .i_Sel(i_Sel),
    .i_Anodos(i_Anodos), .o_Anodos(m_an),
    .o_Segmentos(m_seg), .o_Ovf(m_ovf)
  );

  display_digit_driver #(.P_BLANK_LZ(1'b0)) u_nolz (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Valid(i_Valid), .o_Ready(n_rdy),
    .i_Data(i_Data), .i_Sel(i_Sel),
    .i_Anodos(i_Anodos), .o_Anodos(n_an),
    .o_Segmentos(n_seg), .o_Ovf(n_ovf)
  );

  display_digit_driver #(.P_SEG_ACTIVE_LOW(1'b1)) u_alow (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Valid(i_Valid), .o_Ready(a_rdy),
    .i_Data(i_Data), .i_Sel(i_Sel),
    .i_Anodos(i_Anodos), .o_Anodos(a_an),
    .o_Segmentos(a_seg), .o_Ovf(a_ovf)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic set_sel(input logic [1:0] s);
    i_Sel    = s;
    i_Anodos = 4'b0001 << s;
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
    prev_sel = i_Sel;
    if (scan_en) set_sel(i_Sel + 2'd1);
  endtask

  task automatic check_frame(
    input string tag,
    input seg4_t e,
    input seg4_t n,
    input logic  ovf
  );
    logic [6:0] inv;
    logic [3:0] an;
    for (int i = 0; i < 4; i++) begin
      tick();
      inv = ~e[prev_sel];
      an  = 4'b0001 << prev_sel;
      check({tag, "_seg"},  m_seg, e[prev_sel]);
      check({tag, "_nolz"}, n_seg, n[prev_sel]);
      check({tag, "_alow"}, a_seg, inv);
      check({tag, "_an"},   m_an,  an);
      check({tag, "_ovf"},  m_ovf, ovf);
    end
  endtask

  task automatic load(
    input logic [13:0] v,
    input string       tag
  );
    int n;
    int lat;
    n = 0;
    while (!m_rdy && n < 100) begin
      tick();
      n++;
    end
    i_Valid = 1'b1;
    i_Data  = v;
    tick();
    i_Valid = 1'b0;
    check({tag, "_busy"}, m_rdy, 1'b0);
    lat = 0;
    while (!m_rdy && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_rdy"}, m_rdy, 1'b1);
    check({tag, "_lat_min"}, lat >= 15, 1);
    check({tag, "_lat_max"}, lat <= 18, 1);
    check({tag, "_commit_sel"}, prev_sel, 2'd3);
  endtask

  initial begin
    int rdy_cnt;
    i_Reset  = 1'b1;
    i_Valid  = 1'b0;
    i_Data   = '0;
    scan_en  = 1'b1;
    prev_sel = 2'd0;
    set_sel(2'd0);

    repeat (3) tick();
    check("rst_an",   m_an,  4'b0000);
    check("rst_seg",  m_seg, 7'h00);
    check("rst_alow", a_seg, 7'h7F);
    check("rst_rdy",  m_rdy, 1'b1);
    check("rst_ovf",  m_ovf, 1'b0);
    i_Reset = 1'b0;
    check_frame("rst0",
      '{7'h3F, 7'h00, 7'h00, 7'h00},
      '{7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);

    load(14'd1234, "l1234");
    check_frame("f1234",
      '{7'h66, 7'h4F, 7'h5B, 7'h06},
      '{7'h66, 7'h4F, 7'h5B, 7'h06}, 1'b0);

    load(14'd9999, "l9999");
    check_frame("f9999",
      '{7'h6F, 7'h6F, 7'h6F, 7'h6F},
      '{7'h6F, 7'h6F, 7'h6F, 7'h6F}, 1'b0);

    load(14'd10000, "l10000");
    check_frame("f10000",
      '{7'h40, 7'h40, 7'h40, 7'h40},
      '{7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);

    load(14'd0, "l0");
    check_frame("f0",
      '{7'h3F, 7'h00, 7'h00, 7'h00},
      '{7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);

    load(14'd305, "l305");
    check_frame("f305",
      '{7'h6D, 7'h3F, 7'h4F, 7'h00},
      '{7'h6D, 7'h3F, 7'h4F, 7'h3F}, 1'b0);

    load(14'd7, "l7");
    check_frame("f7",
      '{7'h07, 7'h00, 7'h00, 7'h00},
      '{7'h07, 7'h3F, 7'h3F, 7'h3F}, 1'b0);

    scan_en = 1'b0;
    set_sel(2'd0);
    i_Valid = 1'b1;
    i_Data  = 14'd42;
    tick();
    i_Valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i >= 10 && i < 14) begin
        i_Valid = 1'b1;
        i_Data  = 14'd99;
      end else begin
        i_Valid = 1'b0;
      end
      tick();
    end
    i_Valid = 1'b0;
    check("hold_rdy", m_rdy, 1'b0);
    check("hold_seg", m_seg, 7'h07);
    check("hold_an",  m_an,  4'b0001);
    set_sel(2'd3);
    scan_en = 1'b1;
    tick();
    check("hold_commit", m_rdy, 1'b1);
    check_frame("f42",
      '{7'h5B, 7'h66, 7'h00, 7'h00},
      '{7'h5B, 7'h66, 7'h3F, 7'h3F}, 1'b0);

    i_Valid = 1'b1;
    i_Data  = 14'd8765;
    tick();
    i_Valid = 1'b0;
    check("abort_busy", m_rdy, 1'b0);
    repeat (7) tick();
    i_Reset = 1'b1;
    tick();
    check("abort_rdy", m_rdy, 1'b1);
    check("abort_seg", m_seg, 7'h00);
    check("abort_an",  m_an,  4'b0000);
    check("abort_ovf", m_ovf, 1'b0);
    i_Reset = 1'b0;
    check_frame("abort0",
      '{7'h3F, 7'h00, 7'h00, 7'h00},
      '{7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);
    rdy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_rdy) rdy_cnt++;
    end
    check("abort_idle", rdy_cnt, 20);
    check_frame("abort1",
      '{7'h3F, 7'h00, 7'h00, 7'h00},
      '{7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
